cacheline_adaptor: RTL
======================

# cacheline_adaptor

Converts 256-bit line transactions from the L1 data-cache datapath into 4-beat, 64-bit bursts on the physical-memory port, and back. It sits directly downstream of the data-cache datapath:
- It consumes `cacheline_in`, `cacheline_addr_in` and `cacheline_write` from the datapath.
- It returns `cacheline_out` to the datapath.

## Interface
- `BEATS`, 4: beats per line; fixed, 256/64.
- `clk` in 1: clock, all state on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `line_i` in 256: write-back line (datapath `cacheline_in`).
- `address_i` in 32: line address (datapath `cacheline_addr_in`).
- `read_i` in 1: line fill request, held until `resp_o`.
- `write_i` in 1: write-back request, held until `resp_o`.
- `line_o` out 256: assembled fill line (datapath `cacheline_out`).
- `resp_o` out 1: one-cycle completion pulse.
- `burst_i` in 64: memory read beat data.
- `burst_o` out 64: memory write beat data.
- `address_o` out 32: memory burst address.
- `read_o` out 1: memory read burst request.
- `write_o` out 1: memory write burst request.
- `resp_i` in 1: memory beat strobe; one beat is transferred per cycle in which it is high.

## Operation
- States: IDLE, READ, WRITE, DONE. Beat counter `beat` is 2 bits and wraps modulo 4.
- **IDLE**
  - `write_i`=1: latch `line_i` and `address_i`, clear `beat`, go to WRITE.
  - else `read_i`=1: latch `address_i`, clear `beat`, go to READ.
  - Both high: write wins. The read is not queued; the cache re-asserts it after `resp_o`.
  - `resp_i` is ignored in IDLE.
- **READ**
  - `read_o`=1.
  - Each cycle with `resp_i`=1: `line_o[64*slot +: 64]` <= `burst_i`, where slot = `beat` (aligned), then `beat++`.
  - The beat with `beat`==3 moves the FSM to DONE.
- **WRITE**
  - `write_o`=1; `burst_o` = latched `line[64*beat +: 64]`.
  - Each cycle with `resp_i`=1: `beat++`. The beat with `beat`==3 moves the FSM to DONE.
- `resp_i` low mid-burst: hold state and `beat`; no beat is lost or duplicated.
- **DONE**
  - `resp_o`=1; `read_o`=`write_o`=0.
  - Requests are ignored; unconditional transition to IDLE.
- `address_o`
  - Equals the latched address with bits [4:0] forced to 0 while in READ/WRITE.
  - 0 otherwise.
- `line_o` holds the last completed fill until the next read's first beat overwrites slots. It is valid to the datapath from the `resp_o` cycle onward.
- **Reset (any state)**
  - Next cycle: state IDLE, `beat`=0, `line_o`=0, latched line/address=0.
  - All outputs 0.
  - An in-flight memory burst is abandoned; the memory model must drop it when `read_o`/`write_o` fall.

## Timing
- Reset values: `line_o`=0, `resp_o`=0, `burst_o`=0, `address_o`=0, `read_o`=0, `write_o`=0.
- Request in IDLE at cycle 0 → `read_o`/`write_o` high from cycle 1.
- 4th `resp_i` beat at cycle N → DONE at N+1 (`resp_o`=1, `read_o`/`write_o`=0) → IDLE at N+2.
- Minimum latency, request to `resp_o`: 5 cycles (beats at cycles 1–4).
- `burst_o` changes only on the edge after an accepted beat. Memory may sample it in the same cycle `resp_i` is high.
- Outputs are registered or derived from state plus latched registers only; no combinational path from `burst_i`/`resp_i` to any output.

## Configuration
- Macro: `CACHELINE_ADAPTOR_CWF_EN` (critical-word-first for reads).
- **Defined**
  - READ `address_o` = {latched[31:3], 3'b0}.
  - Memory returns beats starting at start = `address_i[4:3]` and wrapping.
  - Beat k fills slot (start + k) mod 4.
  - Writes are unchanged (aligned, slot 0 first).
- **Undefined**
  - `address_i[4:0]` are ignored for address generation.
  - All bursts are aligned, slot 0 first.

## Test plan
- **Aligned read:** `read_i`=1, `address_i`=0x0000_1240; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → `address_o`=0x0000_1240, `resp_o` 1 cycle after the 4th beat, `line_o`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write-back:** `write_i`=1, `line_i`={D3, D2, D1, D0} → `burst_o` = D0, D1, D2, D3 on successive accepted beats, `write_o` drops on the `resp_o` cycle, `resp_o` exactly once.
- **Stalled burst:** read with `resp_i` pattern 1,0,0,1,1,0,1 → exactly 4 beats captured in order; `resp_o` the cycle after the last 1.
- **Simultaneous request:** `read_i`=`write_i`=1 in IDLE → `write_o`=1, `read_o`=0 throughout; one `resp_o`.
- **Reset mid-burst:** `rst` after 2 read beats → next cycle `read_o`=0, `line_o`=0, no `resp_o`. A following read completes normally.
- **CWF (macro defined):** read `address_i`=0x0000_1250 → `address_o`=0x0000_1250; beats B0..B3 land in slots 2, 3, 0, 1.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// ============================================================================
// Module  : cacheline_adaptor_if
// Brief   : Datapath-side line signals and memory-side burst signals of the
//           cache line adaptor, grouped into one bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cacheline_adaptor_if;
    // Datapath side
    logic [255:0] line_i;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_o;
    logic         resp_o;
    // Memory side
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

`default_nettype wire

// File: rtl/cacheline_adaptor.sv
// ============================================================================
// Module  : cacheline_adaptor
// Brief   : Converts 256-bit cache line transfers to/from 4-beat 64-bit memory
//           bursts. Define CACHELINE_ADAPTOR_CWF_EN for critical-word-first reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adaptor (
    input  wire logic           clk,
    input  wire logic           rst,
    cacheline_adaptor_if.slave  bus
);

    localparam int BEATS = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   beat_q,  beat_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] fill_q,  fill_d;
    logic [31:0]  addr_q,  addr_d;
    logic [1:0]   w_slot;
    logic         w_last;

`ifdef CACHELINE_ADAPTOR_CWF_EN
    // Memory starts the read burst at the requested word and wraps.
    assign w_slot = beat_q + addr_q[4:3];
    logic w_addr_lsb_unused;
    assign w_addr_lsb_unused = ^addr_q[2:0];
`else
    assign w_slot = beat_q;
    logic w_addr_lsb_unused;
    assign w_addr_lsb_unused = ^addr_q[4:0];
`endif

    assign w_last = (beat_q == 2'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wline_d = wline_q;
        fill_d  = fill_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.write_i) begin
                    wline_d = bus.line_i;
                    addr_d  = bus.address_i;
                    beat_d  = 2'd0;
                    state_d = S_WRITE;
                end else if (bus.read_i) begin
                    addr_d  = bus.address_i;
                    beat_d  = 2'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (bus.resp_i) begin
                    fill_d[64*w_slot +: 64] = bus.burst_i;
                    beat_d = beat_q + 2'd1;
                    if (w_last) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (bus.resp_i) begin
                    beat_d = beat_q + 2'd1;
                    if (w_last) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            wline_q <= '0;
            fill_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wline_q <= wline_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
        end
    end

    // All outputs decode registered state only; nothing passes through from resp_i/burst_i.
    assign bus.read_o  = (state_q == S_READ);
    assign bus.write_o = (state_q == S_WRITE);
    assign bus.resp_o  = (state_q == S_DONE);
    assign bus.line_o  = fill_q;
    assign bus.burst_o = (state_q == S_WRITE) ? wline_q[64*beat_q +: 64] : 64'd0;

    always_comb begin
        bus.address_o = 32'd0;
        if (state_q == S_WRITE) begin
            bus.address_o = {addr_q[31:5], 5'd0};
        end else if (state_q == S_READ) begin
`ifdef CACHELINE_ADAPTOR_CWF_EN
            bus.address_o = {addr_q[31:3], 3'd0};
`else
            bus.address_o = {addr_q[31:5], 5'd0};
`endif
        end
    end

endmodule

`default_nettype wire
